imem_loader: RTL

- Writer side of the instruction memory: receives a byte stream (count header plus program words) and produces a one-word-per-cycle write port into the processor's instruction RAM.
- Lets a program be loaded at run time over a byte link instead of only from the memory init file at elaboration.
- `busy` holds the one-cycle processor in reset while a load is in progress.

---
 rtl/imem_loader.sv | 89 ++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction-memory word writer; optional checksum byte when IMEM_LOADER_CHECKSUM_EN is defined
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [31:0]       mem_wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR} state_t;
  state_t state, nxt;
  logic [ADDR_W:0] n;
  logic [1:0] bc;
  logic [23:0] sh;
  logic take, go, last;
  assign take = in_valid && in_ready;
  assign go = start && (state == IDLE || state == DONE || state == ERR);
  assign last = (words_loaded + 1'b1) == n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] cs;
  // running XOR of this load's data bytes, cleared when a load begins
  always_ff @(posedge clk)
    if (reset || go) cs <= '0;
    else if (state == DATA && take) cs <= cs ^ in_data;
`endif
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = COUNT;
      COUNT: if (take) nxt = in_data == 8'd0 ? DONE : 32'(in_data) > DEPTH ? ERR : DATA;
      DATA: if (take && bc == 2'd3) nxt = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      WRITE: nxt = last ? CHECK : DATA;
      CHECK: if (take) nxt = in_data == cs ? DONE : ERR;
`else
      WRITE: nxt = last ? DONE : DATA;
`endif
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb begin
    in_ready = state == COUNT || state == DATA || state == CHECK;
    mem_we = state == WRITE;
    busy = state == COUNT || state == DATA || state == WRITE || state == CHECK;
    done = state == DONE;
    err = state == ERR;
  end
  // word assembly, write port registers and load progress; the write index is words_loaded
  always_ff @(posedge clk) begin
    if (reset) begin
      n <= '0;
      bc <= '0;
      sh <= '0;
      mem_wa <= '0;
      mem_wd <= '0;
      words_loaded <= '0;
    end else begin
      if (go) begin
        words_loaded <= '0;
        bc <= '0;
      end
      if (state == COUNT && take) n <= (ADDR_W+1)'(in_data);
      if (state == DATA && take) begin
        bc <= bc + 2'd1;
        sh <= {sh[15:0], in_data};
        if (bc == 2'd3) begin
          mem_wd <= {sh, in_data};
          mem_wa <= words_loaded[ADDR_W-1:0];
        end
      end
      if (state == WRITE) words_loaded <= words_loaded + 1'b1;
    end
  end
endmodule
